// File: rtl/fetch_unit.sv
// rv32i instruction fetch stage: owns the PC, issues one imem read at a time,
// forwards returned instructions to decode and reports misaligned/bus-error faults.
module fetch_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     ILEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            i_fetch_en,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [ILEN-1:0] i_imem_rdata,
   input  logic            i_imem_err,
   output logic [ILEN-1:0] o_instruction,
   output logic [XLEN-1:0] o_pc,
   output logic            o_decode_en,
   output logic            o_busy,
   output logic            o_fault,
   output logic [1:0]      o_fault_cause
);

   localparam int unsigned        CAUSE_W        = 2;
   localparam logic [CAUSE_W-1:0] CAUSE_NONE     = CAUSE_W'(0);
   localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = CAUSE_W'(1);
   localparam logic [CAUSE_W-1:0] CAUSE_BUS_ERR  = CAUSE_W'(2);
   localparam logic [XLEN-1:0]    PC_STEP        = XLEN'(4);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10
   } state_t;

   state_t               state_q, state_d;
   logic [XLEN-1:0]      pc_q, pc_d;
   logic [XLEN-1:0]      pc_req_q, pc_req_d;
   logic                 kill_q, kill_d;
   logic [ILEN-1:0]      instr_q, instr_d;
   logic [XLEN-1:0]      pc_out_q, pc_out_d;
   logic                 decode_q, decode_d;
   logic                 fault_q, fault_d;
   logic [CAUSE_W-1:0]   cause_q, cause_d;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         pc_req_q <= RESET_PC;
         kill_q   <= 1'b0;
         instr_q  <= '0;
         pc_out_q <= '0;
         decode_q <= 1'b0;
         fault_q  <= 1'b0;
         cause_q  <= CAUSE_NONE;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pc_req_q <= pc_req_d;
         kill_q   <= kill_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         decode_q <= decode_d;
         fault_q  <= fault_d;
         cause_q  <= cause_d;
      end
   end

   // Next-state and next-value logic
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pc_req_d = pc_req_q;
      kill_d   = kill_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      decode_d = 1'b0;
      fault_d  = 1'b0;
      cause_d  = cause_q;

      unique case (state_q)
         ST_IDLE: begin
            if (i_fetch_en) begin
               if (pc_q[1:0] != 2'b00) begin
                  fault_d = 1'b1;
                  cause_d = CAUSE_MISALIGN;
               end else begin
                  pc_req_d = pc_q;
                  state_d  = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (i_imem_gnt) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_imem_rvalid) begin
               state_d = ST_IDLE;
               // A pending or coincident redirect makes this response stale
               if (kill_q || i_redirect) begin
                  kill_d = 1'b0;
               end else if (i_imem_err) begin
                  fault_d = 1'b1;
                  cause_d = CAUSE_BUS_ERR;
               end else begin
                  instr_d  = i_imem_rdata;
                  pc_out_d = pc_req_q;
                  decode_d = 1'b1;
                  pc_d     = pc_req_q + PC_STEP;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Redirect always owns the PC; the in-flight request still completes but is dropped
      if (i_redirect) begin
         pc_d = i_redirect_pc;
         if ((state_q == ST_REQ) || ((state_q == ST_WAIT) && !i_imem_rvalid)) begin
            kill_d = 1'b1;
         end
      end
   end

   assign o_imem_req    = (state_q == ST_REQ);
   assign o_imem_addr   = pc_req_q;
   assign o_busy        = (state_q != ST_IDLE);
   assign o_instruction = instr_q;
   assign o_pc          = pc_out_q;
   assign o_decode_en   = decode_q;
   assign o_fault       = fault_q;
   assign o_fault_cause = cause_q;

   // Bus protocol sanity
   a_addr_stable: assert property (@(posedge clk) disable iff (!rstn)
      (o_imem_req && !i_imem_gnt) |=> (o_imem_req && $stable(o_imem_addr)));
   a_pulse_excl: assert property (@(posedge clk) disable iff (!rstn)
      !(o_decode_en && o_fault));

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic, with a
// transaction-level model compared against the DUT on every cycle.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rstn;
   logic        fetch_en, redirect, gnt, rvalid, err;
   logic [31:0] redirect_pc, rdata;
   logic        imem_req, decode_en, busy, fault;
   logic [31:0] imem_addr, instruction, pc;
   logic [1:0]  fault_cause;

   int checks   = 0;
   int errors   = 0;
   int dec_seen = 0;
   bit chk_en   = 1'b0;

   // Model: phase 0 = no transaction, 1 = request outstanding, 2 = awaiting response
   logic [1:0]  m_phase  = 2'd0;
   logic [31:0] m_pc     = RESET_PC;
   logic [31:0] m_addr   = RESET_PC;
   logic        m_doomed = 1'b0;
   logic [31:0] m_instr  = '0;
   logic [31:0] m_ipc    = '0;
   logic        m_dec    = 1'b0;
   logic        m_fault  = 1'b0;
   logic [1:0]  m_cause  = 2'd0;

   fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .i_fetch_en    (fetch_en),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_gnt    (gnt),
      .i_imem_rvalid (rvalid),
      .i_imem_rdata  (rdata),
      .i_imem_err    (err),
      .o_instruction (instruction),
      .o_pc          (pc),
      .o_decode_en   (decode_en),
      .o_busy        (busy),
      .o_fault       (fault),
      .o_fault_cause (fault_cause)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference behaviour, advanced on each clock from the inputs the bench drove
   always @(posedge clk) begin
      m_dec   <= 1'b0;
      m_fault <= 1'b0;
      if (!rstn) begin
         m_phase  <= 2'd0;
         m_pc     <= RESET_PC;
         m_doomed <= 1'b0;
         m_instr  <= '0;
         m_ipc    <= '0;
         m_cause  <= 2'd0;
      end else begin
         if (m_phase == 2'd0) begin
            if (fetch_en) begin
               if ((m_pc % 32'd4) != 32'd0) begin
                  m_fault <= 1'b1;
                  m_cause <= 2'd1;
               end else begin
                  m_addr  <= m_pc;
                  m_phase <= 2'd1;
               end
            end
         end else if (m_phase == 2'd1) begin
            if (gnt) m_phase <= 2'd2;
         end else if (rvalid) begin
            m_phase <= 2'd0;
            if (m_doomed || redirect) begin
               m_doomed <= 1'b0;
            end else if (err) begin
               m_fault <= 1'b1;
               m_cause <= 2'd2;
            end else begin
               m_instr <= rdata;
               m_ipc   <= m_addr;
               m_dec   <= 1'b1;
               m_pc    <= m_addr + 32'd4;
            end
         end
         if (redirect) begin
            m_pc <= redirect_pc;
            if (m_phase == 2'd1 || (m_phase == 2'd2 && !rvalid)) m_doomed <= 1'b1;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (decode_en) dec_seen++;
      if (chk_en) begin
         chk("req",   32'(imem_req),  32'(m_phase == 2'd1));
         if (m_phase == 2'd1) chk("addr", imem_addr, m_addr);
         chk("busy",  32'(busy),      32'(m_phase != 2'd0));
         chk("dec",   32'(decode_en), 32'(m_dec));
         chk("fault", 32'(fault),     32'(m_fault));
         chk("cause", 32'(fault_cause), 32'(m_cause));
         chk("instr", instruction,    m_instr);
         chk("pc",    pc,             m_ipc);
      end
   end

   task automatic clear_inputs();
      fetch_en = 1'b0;
      redirect = 1'b0;
      gnt      = 1'b0;
      rvalid   = 1'b0;
      err      = 1'b0;
   endtask

   task automatic do_redirect(input logic [31:0] target);
      redirect    = 1'b1;
      redirect_pc = target;
      @(negedge clk);
      redirect = 1'b0;
   endtask

   // One fetch: gw stall cycles before gnt, rvalid rw cycles after gnt.
   // rmode 1: redirect one cycle before rvalid; rmode 2: redirect with rvalid.
   task automatic do_fetch(input logic [31:0] a, input int gw, input int rw,
                           input logic [31:0] data, input logic e,
                           input int rmode, input logic [31:0] rpc);
      fetch_en = 1'b1;
      @(negedge clk);
      fetch_en = 1'b0;
      for (int i = 0; i <= gw; i++) begin
         chk("req_hold",  32'(imem_req), 32'd1);
         chk("addr_hold", imem_addr, a);
         chk("busy_req",  32'(busy), 32'd1);
         if (i == gw) gnt = 1'b1;
         @(negedge clk);
      end
      gnt = 1'b0;
      for (int i = 1; i < rw; i++) begin
         chk("busy_wait", 32'(busy), 32'd1);
         chk("req_wait",  32'(imem_req), 32'd0);
         if (rmode == 1 && i == rw - 1) begin
            redirect    = 1'b1;
            redirect_pc = rpc;
         end
         @(negedge clk);
         redirect = 1'b0;
      end
      chk("busy_rsp", 32'(busy), 32'd1);
      rvalid = 1'b1;
      rdata  = data;
      err    = e;
      if (rmode == 2) begin
         redirect    = 1'b1;
         redirect_pc = rpc;
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      int d0;
      int cd;
      clear_inputs();
      rstn        = 1'b0;
      rdata       = '0;
      redirect_pc = '0;
      cd          = 0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_req",   32'(imem_req), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_instr", instruction, 32'd0);
      chk("rst_pc",    pc, 32'd0);
      chk("rst_cause", 32'(fault_cause), 32'd0);
      rstn = 1'b1;

      // Zero-wait fetch from RESET_PC
      fetch_en = 1'b1;
      @(negedge clk);
      fetch_en = 1'b0;
      chk("t1_req",  32'(imem_req), 32'd1);
      chk("t1_addr", imem_addr, 32'h0);
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      chk("t1_wait_busy", 32'(busy), 32'd1);
      chk("t1_wait_req",  32'(imem_req), 32'd0);
      rvalid = 1'b1;
      rdata  = 32'h0050_0093;
      @(negedge clk);
      rvalid = 1'b0;
      chk("t1_dec",   32'(decode_en), 32'd1);
      chk("t1_instr", instruction, 32'h0050_0093);
      chk("t1_pc",    pc, 32'h0);
      chk("t1_idle",  32'(busy), 32'd0);
      @(negedge clk);
      chk("t1_pulse", 32'(decode_en), 32'd0);

      // Back-pressure: 3 stall cycles, rvalid 2 cycles after gnt
      #1 d0 = dec_seen;
      do_fetch(32'h4, 3, 2, 32'h1234_5678, 1'b0, 0, 32'h0);
      chk("bp_instr", instruction, 32'h1234_5678);
      chk("bp_pc",    pc, 32'h4);
      @(negedge clk);
      #1 chk("bp_one_pulse", 32'(dec_seen - d0), 32'd1);

      // Redirect while waiting, then redirect coincident with rvalid
      do_fetch(32'h8, 0, 3, 32'hDEAD_BEEF, 1'b0, 1, 32'h100);
      chk("rw_dec",   32'(decode_en), 32'd0);
      chk("rw_instr", instruction, 32'h1234_5678);
      do_fetch(32'h100, 1, 1, 32'hCAFE_F00D, 1'b0, 2, 32'h40);
      chk("rc_dec",   32'(decode_en), 32'd0);
      chk("rc_instr", instruction, 32'h1234_5678);
      do_fetch(32'h40, 0, 1, 32'h00A0_0113, 1'b0, 0, 32'h0);
      chk("rc_next_pc", pc, 32'h40);

      // Misaligned PC fault
      do_redirect(32'h102);
      fetch_en = 1'b1;
      @(negedge clk);
      fetch_en = 1'b0;
      chk("mis_fault", 32'(fault), 32'd1);
      chk("mis_cause", 32'(fault_cause), 32'd1);
      chk("mis_req",   32'(imem_req), 32'd0);
      @(negedge clk);
      chk("mis_pulse", 32'(fault), 32'd0);
      chk("mis_hold",  32'(fault_cause), 32'd1);

      // Bus error leaves the PC where it was
      do_redirect(32'h200);
      do_fetch(32'h200, 1, 2, 32'hFFFF_FFFF, 1'b1, 0, 32'h0);
      chk("be_fault", 32'(fault), 32'd1);
      chk("be_cause", 32'(fault_cause), 32'd2);
      chk("be_dec",   32'(decode_en), 32'd0);
      do_fetch(32'h200, 0, 1, 32'h0000_0013, 1'b0, 0, 32'h0);
      chk("be_retry_pc", pc, 32'h200);
      chk("be_cause_held", 32'(fault_cause), 32'd2);

      // PC wraps past the top of the address space
      do_redirect(32'hFFFF_FFFC);
      do_fetch(32'hFFFF_FFFC, 0, 1, 32'h1111_1111, 1'b0, 0, 32'h0);
      chk("wrap_pc", pc, 32'hFFFF_FFFC);
      do_fetch(32'h0, 0, 1, 32'h3333_3333, 1'b0, 0, 32'h0);

      // Reset while waiting; the late response must be ignored
      fetch_en = 1'b1;
      @(negedge clk);
      fetch_en = 1'b0;
      chk("rs_addr", imem_addr, 32'h4);
      gnt = 1'b1;
      @(negedge clk);
      gnt  = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("rs_req",   32'(imem_req), 32'd0);
      chk("rs_busy",  32'(busy), 32'd0);
      chk("rs_instr", instruction, 32'h0);
      rvalid = 1'b1;
      rdata  = 32'h2222_2222;
      @(negedge clk);
      rvalid = 1'b0;
      chk("rs_late_dec",  32'(decode_en), 32'd0);
      chk("rs_late_busy", 32'(busy), 32'd0);
      do_fetch(RESET_PC, 0, 1, 32'h4444_4444, 1'b0, 0, 32'h0);
      chk("rs_refetch", pc, RESET_PC);

      // Randomized traffic with a responsive memory
      for (int c = 0; c < 3000; c++) begin
         rstn        = ($urandom_range(0, 199) != 0);
         fetch_en    = ($urandom_range(0, 2) == 0);
         redirect    = !fetch_en && ($urandom_range(0, 9) == 0);
         redirect_pc = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFFC;
         gnt = (m_phase == 2'd1) && ($urandom_range(0, 2) == 0);
         if (gnt) cd = $urandom_range(0, 3);
         if (m_phase == 2'd2) begin
            if (cd == 0) begin
               rvalid = 1'b1;
            end else begin
               rvalid = 1'b0;
               cd--;
            end
         end else begin
            rvalid = ($urandom_range(0, 19) == 0);
         end
         rdata = $urandom();
         err   = ($urandom_range(0, 7) == 0);
         @(negedge clk);
      end
      clear_inputs();
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage for the rv32i core. It owns the program counter, issues one instruction-memory read at a time over a request/grant + response handshake, and hands each returned instruction to decode with a one-cycle decode-enable pulse. It accepts branch/jump redirects from execute and reports misaligned-PC and bus-error faults.

Parameters:
XLEN, 32, address / PC width
ILEN, 32, instruction width
RESET_PC, 0, PC value loaded on reset (must be 4-byte aligned)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
i_fetch_en  in  1  start one fetch at the current PC; sampled only in IDLE
i_redirect  in  1  load i_redirect_pc into PC; may be asserted in any state
i_redirect_pc  in  XLEN  redirect target
o_imem_req  out  1  memory read request valid
o_imem_addr  out  XLEN  read address; stable while o_imem_req=1 and i_imem_gnt=0
i_imem_gnt  in  1  request accepted in this cycle
i_imem_rvalid  in  1  read response valid; earliest one cycle after the gnt cycle
i_imem_rdata  in  ILEN  read data
i_imem_err  in  1  bus error; qualified by i_imem_rvalid
o_instruction  out  ILEN  last successfully fetched instruction (drives decode i_instruction)
o_pc  out  XLEN  address of o_instruction
o_decode_en  out  1  one-cycle pulse when o_instruction/o_pc update
o_busy  out  1  state != IDLE
o_fault  out  1  one-cycle fault pulse
o_fault_cause  out  2  01 misaligned PC, 10 bus error; held until next fault

Behaviour:
- Reset (rstn=0 at clk edge): pc<=RESET_PC, state<=IDLE, kill<=0; o_instruction, o_pc, o_decode_en, o_fault, o_fault_cause <=0. o_imem_req=0 in the cycle after reset. Reset mid-fetch abandons the transaction; any later rvalid is ignored because state is IDLE.
- o_imem_req = (state==REQ); o_imem_addr = pc_req, the PC captured when the fetch was launched; o_busy combinational from state.
- IDLE: if i_fetch_en and pc[1:0]!=0, pulse o_fault, set cause=01, stay IDLE, no request. If i_fetch_en and pc is aligned, capture pc_req<=pc and go to REQ. i_fetch_en outside IDLE is ignored.
- REQ: hold req/addr. On i_imem_gnt, go to WAIT.
- WAIT: wait for i_imem_rvalid.
  - rvalid with kill=1: discard the response, clear kill, go to IDLE; no pulse, no fault.
  - rvalid with err=1: pulse o_fault, set cause=10, pc unchanged, go to IDLE.
  - Otherwise: o_instruction<=rdata, o_pc<=pc_req, o_decode_en<=1 for one cycle, pc<=pc_req+4 (modulo 2^XLEN, so 0xFFFFFFFC wraps to 0), go to IDLE.
- Redirect:
  - pc<=i_redirect_pc in any state.
  - In REQ or WAIT, it also sets kill=1, so the in-flight response is dropped.
  - REQ is never withdrawn before gnt: request stability has priority.
  - Redirect in the same cycle as a good rvalid: redirect wins over pc+4, and that response is killed.
  - A misaligned redirect target is reported only when the next fetch is attempted.
- Minimum latency: fetch_en @N -> req @N+1 -> gnt @N+1 -> rvalid @N+2 -> o_decode_en=1 with new o_instruction @N+3.
- Single outstanding transaction. rvalid in IDLE/REQ is ignored.

Test Plan:
- Reset then zero-wait fetch: RESET_PC=0, fetch_en@1, gnt@2, rvalid@3 with rdata=0x00500093 -> req@2 addr=0, decode_en@4, o_instruction=0x00500093, o_pc=0, next addr=4.
- Back-pressure: gnt held low 3 cycles, then rvalid 2 cycles after gnt -> addr stable throughout, exactly one decode_en pulse, o_busy high for the entire fetch.
- Redirect in WAIT: redirect_pc=0x100 one cycle before rvalid -> no decode_en, o_instruction unchanged, next fetch addr=0x100.
- Redirect coincident with good rvalid: rvalid plus redirect to 0x40 in the same cycle -> response dropped, next addr=0x40.
- Faults: redirect to 0x102 then fetch_en -> o_fault, cause=01, no req. Aligned fetch returning rvalid+err -> o_fault, cause=10, PC unchanged.
- Wrap and reset: fetch at 0xFFFFFFFC -> next PC 0. Assert rstn=0 during WAIT -> req=0, later rvalid ignored, next fetch addr=RESET_PC.
